// File: rtl/axis_fifo_wide_to_narrow.sv
// Wide-to-narrow AXI-Stream FIFO: stores IN_WIDTH words with keep/last and
// unpacks each word into OUT_WIDTH lanes, LSB lane first, skipping unkept upper lanes.
module axis_fifo_wide_to_narrow #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   s_axis_tdata,
    input  logic [IN_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int KEEP_W    = IN_WIDTH / 8;
    localparam int LANE_KEEP = OUT_WIDTH / 8;
    localparam int LANE_W    = $clog2(RATIO);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {EMPTY, SEND} state_t;

    // Index of the highest lane with any keep bit set; lane 0 when none are.
    function automatic logic [LANE_W-1:0] last_lane(input logic [KEEP_W-1:0] keep);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = 1; i < RATIO; i++)
            if (|keep[i*LANE_KEEP +: LANE_KEEP]) idx = LANE_W'(i);
        return idx;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] lane_of(input logic [IN_WIDTH-1:0] word,
                                                     input logic [LANE_W-1:0]   idx);
        return word[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    logic [IN_WIDTH-1:0] mem_data [DEPTH];
    logic [KEEP_W-1:0]   mem_keep [DEPTH];
    logic                mem_last [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CNT_W-1:0]  count, count_next;
    logic [LANE_W-1:0] lane_idx, head_end;
    state_t            state, state_next;

    logic                push, pop, handshake;
    logic                load;
    logic [LANE_W-1:0]   load_idx;
    logic [IN_WIDTH-1:0] sel_data;
    logic                sel_last;
    logic [LANE_W-1:0]   sel_end;

    assign push       = s_axis_tvalid && s_axis_tready;
    assign handshake  = (state == SEND) && m_axis_tready;
    assign head_end   = last_lane(mem_keep[rd_ptr]);
    assign pop        = handshake && (lane_idx == head_end);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_keep[wr_ptr] <= s_axis_tkeep;
            mem_last[wr_ptr] <= s_axis_tlast;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count         <= count_next;
            s_axis_tready <= (count_next < DEPTH_C);
        end
    end

    // Unpacker state register, together with the lane output register it steers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            lane_idx     <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                lane_idx     <= load_idx;
                m_axis_tdata <= lane_of(sel_data, load_idx);
                m_axis_tlast <= sel_last && (load_idx == sel_end);
            end
        end
    end

    // When the only stored word pops while a new word arrives, lane 0 comes straight from the input
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_idx   = '0;
        sel_data   = mem_data[rd_ptr];
        sel_last   = mem_last[rd_ptr];
        sel_end    = head_end;
        case (state)
            EMPTY: begin
                if (count != '0) begin
                    state_next = SEND;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!pop) begin
                        load     = 1'b1;
                        load_idx = lane_idx + LANE_W'(1);
                    end else if (count > CNT_W'(1)) begin
                        load     = 1'b1;
                        sel_data = mem_data[rd_ptr_inc];
                        sel_last = mem_last[rd_ptr_inc];
                        sel_end  = last_lane(mem_keep[rd_ptr_inc]);
                    end else if (push) begin
                        load     = 1'b1;
                        sel_data = s_axis_tdata;
                        sel_last = s_axis_tlast;
                        sel_end  = last_lane(s_axis_tkeep);
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (state == SEND);
    end

endmodule

// File: tb/tb_axis_fifo_wide_to_narrow.sv
// Directed bench for axis_fifo_wide_to_narrow: vector table of single words plus
// sequences for latency, throughput, full FIFO, random backpressure and mid-packet reset.
module tb_axis_fifo_wide_to_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    axis_fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prod_done;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          n;
        logic [8:0]  lanes [4];
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [8:0] obs_at(input int j);
        if (j < obs_q.size()) return obs_q[j];
        return 9'h1FF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit done;
        done    = 1'b0;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) check("send timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_lanes(input int n, input int budget);
        for (int c = 0; c < budget && obs_q.size() < n; c++) tick();
    endtask

    // Records every accepted lane and checks that stalled outputs hold still
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall hold", {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, prev_last, prev_data});
            if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    initial begin
        int errs;
        vecs[0] = '{32'h44332211, 4'hF, 1'b1, 4, '{9'h011, 9'h022, 9'h033, 9'h144}};
        vecs[1] = '{32'h00CCBBAA, 4'h7, 1'b1, 3, '{9'h0AA, 9'h0BB, 9'h1CC, 9'h000}};
        vecs[2] = '{32'h12345678, 4'h1, 1'b1, 1, '{9'h178, 9'h000, 9'h000, 9'h000}};
        vecs[3] = '{32'hA1B2C3D4, 4'h3, 1'b0, 2, '{9'h0D4, 9'h0C3, 9'h000, 9'h000}};
        vecs[4] = '{32'hDEADBEEF, 4'h0, 1'b1, 1, '{9'h1EF, 9'h000, 9'h000, 9'h000}};
        vecs[5] = '{32'h55667788, 4'hF, 1'b0, 4, '{9'h088, 9'h077, 9'h066, 9'h055}};

        rst = 1'b1; s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset m_valid", {31'd0, m_valid}, 32'd0);
        check("reset m_data",  {24'd0, m_data},  32'd0);
        check("reset m_last",  {31'd0, m_last},  32'd0);
        check("reset s_ready", {31'd0, s_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("s_ready before first edge", {31'd0, s_ready}, 32'd0);
        tick();
        check("s_ready after first edge", {31'd0, s_ready}, 32'd1);

        // One-cycle latency, four consecutive lanes
        m_ready = 1'b1;
        s_data = 32'h44332211; s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        check("lat valid low after accept", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lat lane", {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, (i == 3), 8'(8'h11 * (i + 1))});
        end
        @(negedge clk);
        check("lat valid low after word", {31'd0, m_valid}, 32'd0);
        tick();

        for (int v = 0; v < 6; v++) begin
            obs_q.delete();
            send_word(vecs[v].data, vecs[v].keep, vecs[v].last);
            wait_lanes(vecs[v].n, 20);
            repeat (3) tick();
            check("vec lane count", obs_q.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++)
                check("vec lane", {23'd0, obs_at(i)}, {23'd0, vecs[v].lanes[i]});
        end

        // Back-to-back words: no bubble between them
        obs_q.delete();
        s_data = 32'h04030201; s_keep = 4'hF; s_last = 1'b0; s_valid = 1'b1;
        @(posedge clk);
        #1 s_data = 32'h08070605; s_last = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid) errs++;
        end
        check("throughput valid cycles", errs, 8);
        @(negedge clk);
        check("throughput valid low", {31'd0, m_valid}, 32'd0);
        tick();
        check("throughput word A end", {23'd0, obs_at(3)}, {23'd0, 9'h004});
        check("throughput word B start", {23'd0, obs_at(4)}, {23'd0, 9'h005});
        check("throughput word B end", {23'd0, obs_at(7)}, {23'd0, 9'h108});

        // Fill to DEPTH with the output stalled
        obs_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_word(32'h01010101 * i, 4'hF, 1'b0);
        check("full s_ready low", {31'd0, s_ready}, 32'd0);
        s_data = 32'h10101010; s_keep = 4'hF; s_last = 1'b0; s_valid = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("full ready held low", {31'd0, s_ready}, 32'd0);
        end
        @(negedge clk);
        check("ready after 4th lane", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        wait_lanes(68, 400);
        check("full drain count", obs_q.size(), 68);
        errs = 0;
        for (int j = 0; j < 68; j++)
            if (obs_at(j) !== {1'b0, 8'(j / 4)}) errs++;
        check("full drain mismatches", errs, 0);

        // Random valid/ready over 200 packets
        obs_q.delete();
        exp_q.delete();
        prod_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    int nw;
                    nw = $urandom_range(1, 3);
                    for (int w = 0; w < nw; w++) begin
                        logic [31:0] d;
                        logic        l;
                        int          nb, nl;
                        d  = $urandom;
                        l  = (w == nw - 1);
                        nb = l ? $urandom_range(0, 4) : 4;
                        nl = (nb == 0) ? 1 : nb;
                        for (int b = 0; b < nl; b++)
                            exp_q.push_back({l && (b == nl - 1), d[8*b +: 8]});
                        repeat ($urandom_range(0, 2)) tick();
                        send_word(d, 4'((5'd1 << nb) - 5'd1), l);
                    end
                end
                prod_done = 1'b1;
            end
            begin
                for (int c = 0; c < 20000; c++) begin
                    tick();
                    m_ready = 1'($urandom_range(0, 1));
                    if (prod_done && obs_q.size() >= exp_q.size()) break;
                end
                m_ready = 1'b1;
            end
        join
        repeat (5) tick();
        check("bp lane count", obs_q.size(), exp_q.size());
        errs = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (obs_at(j) !== exp_q[j]) errs++;
        check("bp stream mismatches", errs, 0);

        // Reset after two lanes of a three-word packet
        m_ready = 1'b0;
        obs_q.delete();
        send_word(32'h13121110, 4'hF, 1'b0);
        send_word(32'h17161514, 4'hF, 1'b0);
        send_word(32'h1B1A1918, 4'hF, 1'b1);
        m_ready = 1'b1;
        for (int c = 0; c < 20 && obs_q.size() < 2; c++) tick();
        check("pre-reset lanes", obs_q.size(), 2);
        rst = 1'b1;
        #1;
        check("rst m_valid", {31'd0, m_valid}, 32'd0);
        check("rst m_data",  {24'd0, m_data},  32'd0);
        check("rst s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post-rst s_ready", {31'd0, s_ready}, 32'd1);
        check("post-rst m_valid", {31'd0, m_valid}, 32'd0);
        obs_q.delete();
        send_word(32'h0D0C0B0A, 4'hF, 1'b1);
        wait_lanes(4, 50);
        repeat (3) tick();
        check("post-rst lane count", obs_q.size(), 4);
        check("post-rst first lane", {23'd0, obs_at(0)}, {23'd0, 9'h00A});
        check("post-rst last lane",  {23'd0, obs_at(3)}, {23'd0, 9'h10D});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_fifo_wide_to_narrow.md
AXIS_FIFO_WIDE_TO_NARROW -- requirements
Module: axis_fifo_wide_to_narrow

Interface
REQ-001 Parameters SHALL be, one per line:
  IN_WIDTH, 32, input data width in bits; multiple of 8.
  OUT_WIDTH, 8, output data width in bits; multiple of 8; IN_WIDTH/OUT_WIDTH (RATIO) a power of two, at least 2.
  DEPTH, 16, storage depth in IN_WIDTH words; power of two, at least 2.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all logic on rising edge.
  rst  input  1  asynchronous, active-high reset.
  s_axis_tdata  input  IN_WIDTH  wide input word.
  s_axis_tkeep  input  IN_WIDTH/8  byte enables; contiguous from LSB.
  s_axis_tvalid  input  1  input word valid.
  s_axis_tready  output  1  input word accepted when high with tvalid.
  s_axis_tlast  input  1  last word of packet.
  m_axis_tdata  output  OUT_WIDTH  narrow output lane.
  m_axis_tvalid  output  1  output lane valid.
  m_axis_tready  input  1  downstream accepts lane.
  m_axis_tlast  output  1  last lane of packet.
REQ-003 One clock; reset asynchronous and active-high; clock port clk, reset port rst.

Function
REQ-004 Storage SHALL be a DEPTH-entry array of {tdata, tkeep, tlast} words, with write pointer, read pointer and occupancy count.
REQ-005 A word SHALL be written when s_axis_tvalid and s_axis_tready are both high at a rising edge; the write pointer then wraps modulo DEPTH.
REQ-006 s_axis_tready SHALL be a register, high exactly when count < DEPTH; no same-cycle pass-through when full.
REQ-007 Lane i of a word SHALL be bits [(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH], emitted in order LSB lane first (i = 0 .. RATIO-1).
REQ-008 A lane SHALL be emitted if any of its keep bits is set; lane 0 is always emitted; lanes above the highest kept lane are skipped without consuming cycles.
REQ-009 The unpacker FSM SHALL have two states:
  EMPTY: m_axis_tvalid=0.
  SEND: output register holds one lane.
REQ-010 EMPTY->SEND SHALL occur at the edge where count>0; lane 0 of the head word is loaded and m_axis_tvalid is high in the next cycle.
REQ-011 In SEND, on an m_axis handshake, the next lane SHALL be loaded if one remains; otherwise the word SHALL be popped, and the FSM SHALL load lane 0 of the next word if count>1 (or a write occurs that cycle) or else go to EMPTY.
REQ-012 Latency SHALL be one cycle: a word accepted at edge k into an empty FIFO gives m_axis_tvalid high after edge k+1.
REQ-013 Sustained throughput SHALL be one lane per cycle with no bubble between words.
REQ-014 m_axis_tdata and m_axis_tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 m_axis_tlast SHALL be 1 only on the last emitted lane of a word stored with tlast=1.
REQ-016 Word pop and push in the same cycle SHALL leave count unchanged.
REQ-017 A word's storage entry SHALL be freed only when its last emitted lane is accepted, so s_axis_tready can rise in the cycle after that edge.
REQ-018 Count SHALL be $clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH or go below 0.

Reset
REQ-019 While rst=1, the following SHALL be held at 0, asynchronously: pointers, count, lane index, m_axis_tvalid, m_axis_tlast, m_axis_tdata and s_axis_tready; the FSM SHALL be in EMPTY.
REQ-020 s_axis_tready SHALL go to 1 at the first rising edge after rst deasserts.
REQ-021 Reset asserted mid-packet SHALL discard all stored and partially sent data; no lane from before reset may appear afterward.

Verification
REQ-022 Single word 0x44332211, tkeep=0xF, tlast=1, m_axis_tready=1 -> lanes 0x11, 0x22, 0x33, 0x44 on four consecutive cycles starting one cycle after accept; tlast only on 0x44.
REQ-023 Word 0x00CCBBAA, tkeep=0x7, tlast=1 -> lanes 0xAA, 0xBB, 0xCC; tlast on 0xCC; 0x00 never emitted.
REQ-024 Write 17 words with m_axis_tready=0 -> 16 accepted; s_axis_tready=0 after the 16th; the 17th is accepted one cycle after the first word's fourth lane is taken.
REQ-025 Random tvalid/tready backpressure over 200 packets -> output byte stream and tlast positions match a reference model exactly; m_axis_tdata is stable during stalls.
REQ-026 rst pulsed after 2 lanes of a 3-word packet -> m_axis_tvalid=0 immediately; s_axis_tready=1 after the next edge; the first post-reset lane is the first lane of the new input.
